rf_dump_reader: RTL and testbench
=================================

Name: rf_dump_reader

Overview:
- Debug read-side engine for the 32x32 register file.
- On request, it walks the RF read port across r0..r31 and streams {index, value} beats over a valid/ready interface to the trace/log sink.
- It can skip zero-valued registers.
- It drives one RF read-address port and asserts busy so the core stalls and the RF stays unchanged for the whole dump.

Parameters:
- NREGS, 32, number of registers scanned.
- AW, 5, register address width (log2 NREGS).
- DW, 32, register data width.
- CNT_W, 16, width of the completed-dump counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to begin a dump; honoured only in IDLE.
- skip_zero  in  1  sampled with start; 1 = suppress beats for registers whose value is 0.
- abort  in  1  synchronous cancel of a dump in progress.
- rf_ra  out  AW  RF read address.
- rf_rd  in  DW  RF read data, combinational from rf_ra.
- busy  out  1  high whenever state != IDLE; core stalls on it.
- out_valid  out  1  beat valid.
- out_ready  in  1  sink accepts beat.
- out_idx  out  AW  register index of the beat.
- out_data  out  DW  register value of the beat.
- out_last  out  1  high when out_idx == NREGS-1.
- done  out  1  one-cycle pulse at normal completion.
- dump_count  out  CNT_W  completed dumps, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, skip latch=0, out_valid=0, out_idx=0, out_data=0, done=0, dump_count=0. Outputs rf_ra=0, busy=0, out_last=0.
- IDLE:
  - rf_ra=0.
  - start=1: latch skip_zero, idx<=0, go to SCAN.
  - start while not IDLE is ignored.
- SCAN:
  - rf_ra=idx; rf_rd is sampled in the same cycle.
  - If skip latch=1 and rf_rd==0:
    - idx<NREGS-1: idx<=idx+1, stay in SCAN.
    - idx==NREGS-1: go to DONE with no beat.
  - Otherwise: out_data<=rf_rd, out_idx<=idx, out_valid<=1, go to EMIT.
- EMIT:
  - rf_ra=idx.
  - out_valid/out_idx/out_data stay stable until out_valid&&out_ready.
  - On handshake: out_valid<=0. If idx==NREGS-1 go to DONE, else idx<=idx+1 and go to SCAN.
  - out_ready is a don't-care while out_valid=0.
- DONE: done=1 for exactly this cycle, dump_count<=dump_count+1, go to IDLE.
- Throughput and latency:
  - One emitted beat costs at least 2 cycles (SCAN+EMIT); one skipped register costs 1 cycle.
  - First out_valid appears 2 cycles after the start cycle.
  - A full unskipped dump with out_ready tied high takes 1+64+1 cycles from start to done.
- skip_zero=1: r0 is never emitted, because it always reads 0.
- End marker:
  - out_last is set only on the r31 beat.
  - If r31 is skipped, no beat carries out_last; done is the authoritative end marker.
- Abort (any non-IDLE state): next edge goes to IDLE, out_valid<=0, no done, dump_count unchanged. A beat handshaken in the same cycle as abort counts as delivered.
- Start and abort in the same IDLE cycle: abort wins and the dump does not start.
- rst mid-dump: immediate return to reset values, no done.

Decomposition:
- Shared package rf_dbg_pkg:
  - NREGS, AW, DW constants.
  - State enum {IDLE, SCAN, EMIT, DONE}, 2-bit.
  - Beat struct {idx[AW], data[DW], last}, reused by the trace sink.
- No sub-module: a single FSM plus index and dump counters.

Test Plan:
- Full dump: RF r1=0x11, r5=0xDEADBEEF, all others 0; skip_zero=0, out_ready=1 -> 32 beats idx 0..31 in order, beat5 data=0xDEADBEEF, out_last only on idx31, done 66 cycles after start, dump_count=1.
- Sparse dump: same RF, skip_zero=1 -> exactly 2 beats (1,0x11),(5,0xDEADBEEF); no out_last; done pulses once; busy falls the cycle after done.
- Backpressure: skip_zero=0, out_ready low for 7 cycles on beat idx3 -> out_valid/out_idx=3/out_data held constant all 7 cycles, no beat lost or duplicated, 32 beats total.
- Abort: abort asserted while in EMIT with idx=10 -> out_valid=0 and busy=0 next cycle, no done, dump_count unchanged; a following start gives a fresh dump starting at idx 0.
- Async reset: rst pulsed between clock edges mid-SCAN -> outputs reach reset values before the next edge; start ignored while rst=1.
- Start while busy: second start pulse at idx=4 -> ignored, single done; run 65536 dumps with CNT_W=16 -> dump_count wraps to 0.

Source files
------------

// File: rtl/rf_dbg_pkg.sv
// Shared types and constants for the register-file debug dump path.
package rf_dbg_pkg;

    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CNT_W = 16;

    // Dump engine states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_e;

    // One {index, value} trace beat as seen by the trace sink.
    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

endpackage

// File: rtl/rf_dump_reader.sv
// Debug read-side engine: walks the RF read port over r0..NREGS-1 and streams
// {index, value} beats over valid/ready, optionally skipping zero registers.
// busy stalls the core so the RF is frozen for the whole dump.
module rf_dump_reader #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             skip_zero,
    input  logic             abort,
    output logic [AW-1:0]    rf_ra,
    input  logic [DW-1:0]    rf_rd,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    out_idx,
    output logic [DW-1:0]    out_data,
    output logic             out_last,
    output logic             done,
    output logic [CNT_W-1:0] dump_count
);

    import rf_dbg_pkg::*;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             skip_q, skip_d;
    logic             valid_q, valid_d;
    logic [AW-1:0]    oidx_q, oidx_d;
    logic [DW-1:0]    odata_q, odata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and beat registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            skip_q  <= 1'b0;
            valid_q <= 1'b0;
            oidx_q  <= '0;
            odata_q <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            skip_q  <= skip_d;
            valid_q <= valid_d;
            oidx_q  <= oidx_d;
            odata_q <= odata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, read address and done pulse; abort overrides any non-idle state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        skip_d  = skip_q;
        valid_d = valid_q;
        oidx_d  = oidx_q;
        odata_d = odata_q;
        cnt_d   = cnt_q;
        rf_ra   = '0;
        done    = 1'b0;

        if (state_q != IDLE) begin
            rf_ra = idx_q;
        end

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // start and abort together in IDLE: abort wins.
                    if (start && !abort) begin
                        skip_d  = skip_zero;
                        idx_d   = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (skip_q && rf_rd == '0) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        odata_d = rf_rd;
                        oidx_d  = idx_q;
                        valid_d = 1'b1;
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        valid_d = 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = SCAN;
                        end
                    end
                end
                DONE: begin
                    done    = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign out_valid  = valid_q;
    assign out_idx    = oidx_q;
    assign out_data   = odata_q;
    assign out_last   = valid_q && (oidx_q == LAST_IDX);
    assign dump_count = cnt_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader: table of dump scenarios plus hand-written
// reset, abort and counter-wrap sequences. A second instance with a 3-bit
// counter runs in lockstep to exercise counter wrap in few cycles.
module tb_rf_dump_reader;

    logic        clk = 1'b0;
    logic        rst, start, skip_zero, abort, out_ready;
    logic [4:0]  rf_ra, s_rf_ra;
    logic [31:0] rf_rd, s_rf_rd;
    logic        busy, out_valid, out_last, done;
    logic [4:0]  out_idx;
    logic [31:0] out_data;
    logic [15:0] dump_count;
    logic        s_busy, s_out_valid, s_out_last, s_done;
    logic [4:0]  s_out_idx;
    logic [31:0] s_out_data;
    logic [2:0]  s_dump_count;

    logic [31:0] rf_mem [32];

    assign rf_rd   = rf_mem[rf_ra];
    assign s_rf_rd = rf_mem[s_rf_ra];

    always #5 clk = ~clk;

    rf_dump_reader #(.NREGS(32), .AW(5), .DW(32), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .skip_zero(skip_zero), .abort(abort),
        .rf_ra(rf_ra), .rf_rd(rf_rd), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
        .out_last(out_last), .done(done), .dump_count(dump_count)
    );

    rf_dump_reader #(.NREGS(32), .AW(5), .DW(32), .CNT_W(3)) u_small (
        .clk(clk), .rst(rst), .start(start), .skip_zero(skip_zero), .abort(abort),
        .rf_ra(s_rf_ra), .rf_rd(s_rf_rd), .busy(s_busy), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_idx(s_out_idx), .out_data(s_out_data),
        .out_last(s_out_last), .done(s_done), .dump_count(s_dump_count)
    );

    int checks   = 0;
    int failures = 0;
    int exp_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic skip;
        int   stall_idx;
        int   stall_len;
        int   restart_idx;
        int   exp_beats;
        int   exp_cycles;
        bit   exp_last;
    } vec_t;

    vec_t vecs [4];

    // Results of the most recent run_dump.
    int nbeats, cycles, ndone;
    bit last_seen, content_ok, hold_ok, busy_ok;
    logic busy_after;

    // Drives one dump and records beats against the RF model. cycles counts
    // the start cycle as 1 and stops at the cycle where done is seen.
    task automatic run_dump(input logic skip, input int stall_idx, input int stall_len,
                            input int restart_idx);
        int exp_i;
        int stall_cnt;
        bit restarted;
        bit done_seen;
        logic [4:0]  h_idx;
        logic [31:0] h_data;
        nbeats = 0; cycles = 0; ndone = 0;
        last_seen = 0; content_ok = 1; hold_ok = 1; busy_ok = 1;
        exp_i = 0; stall_cnt = 0; restarted = 0; done_seen = 0;
        h_idx = '0; h_data = '0;
        @(negedge clk);
        start = 1'b1; skip_zero = skip; out_ready = 1'b1;
        cycles = 1;
        for (int c = 0; c < 500 && !done_seen; c++) begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
            if (!busy) busy_ok = 0;
            if (done) begin
                ndone++;
                done_seen = 1;
            end
            if (out_valid) begin
                if (int'(out_idx) == stall_idx && stall_cnt < stall_len) begin
                    if (stall_cnt == 0) begin
                        h_idx  = out_idx;
                        h_data = out_data;
                    end else if (out_idx !== h_idx || out_data !== h_data) begin
                        hold_ok = 0;
                    end
                    stall_cnt++;
                    out_ready = 1'b0;
                end else begin
                    out_ready = 1'b1;
                    while (exp_i < 32 && skip && rf_mem[exp_i] == 32'd0) exp_i++;
                    if (exp_i >= 32 || out_idx !== 5'(exp_i) || out_data !== rf_mem[exp_i])
                        content_ok = 0;
                    if (out_last !== (out_idx == 5'd31)) content_ok = 0;
                    if (out_last) last_seen = 1;
                    exp_i++;
                    nbeats++;
                end
                if (int'(out_idx) == restart_idx && !restarted) begin
                    start = 1'b1;
                    restarted = 1;
                end
            end
        end
        @(negedge clk);
        busy_after = busy;
        if (done) ndone++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
        rf_mem[1] = 32'h0000_0011;
        rf_mem[5] = 32'hDEAD_BEEF;

        //            skip  stall_idx stall_len restart beats cycles last
        vecs[0] = '{1'b0, -1, 0, -1, 32, 66, 1'b1};   // full dump
        vecs[1] = '{1'b1, -1, 0, -1,  2, 36, 1'b0};   // sparse dump
        vecs[2] = '{1'b0,  3, 7, -1, 32, 73, 1'b1};   // backpressure on idx3
        vecs[3] = '{1'b0, -1, 0,  4, 32, 66, 1'b1};   // start while busy

        // Reset state, with start held high during reset.
        rst = 1'b1; start = 1'b1; skip_zero = 1'b0; abort = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_rf_ra", rf_ra, 5'd0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_idx", out_idx, 5'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dump_count", dump_count, 16'd0);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_rst", busy, 1'b0);

        // Async reset mid-SCAN: pulse rst between edges.
        start = 1'b1; skip_zero = 1'b1;
        @(negedge clk); start = 1'b0;            // SCAN idx0
        @(negedge clk);                          // SCAN idx1
        check("midscan_rf_ra", rf_ra, 5'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_rf_ra", rf_ra, 5'd0);
        check("async_rst_valid", out_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("async_rst_stays_idle", busy, 1'b0);

        // Table-driven dump scenarios.
        for (int v = 0; v < 4; v++) begin
            run_dump(vecs[v].skip, vecs[v].stall_idx, vecs[v].stall_len, vecs[v].restart_idx);
            exp_count++;
            check($sformatf("v%0d_beats", v), nbeats, vecs[v].exp_beats);
            check($sformatf("v%0d_cycles", v), cycles, vecs[v].exp_cycles);
            check($sformatf("v%0d_done_once", v), ndone, 1);
            check($sformatf("v%0d_content", v), content_ok, 1'b1);
            check($sformatf("v%0d_hold", v), hold_ok, 1'b1);
            check($sformatf("v%0d_busy_during", v), busy_ok, 1'b1);
            check($sformatf("v%0d_busy_after", v), busy_after, 1'b0);
            check($sformatf("v%0d_last_seen", v), last_seen, vecs[v].exp_last);
            check($sformatf("v%0d_dump_count", v), dump_count, exp_count);
        end

        // Abort while in EMIT with idx=10.
        begin
            bit found;
            bit done_seen;
            found = 0; done_seen = 0;
            @(negedge clk);
            start = 1'b1; skip_zero = 1'b0; out_ready = 1'b1;
            for (int c = 0; c < 200 && !found; c++) begin
                @(negedge clk);
                start = 1'b0;
                if (done) done_seen = 1;
                if (out_valid && out_idx == 5'd10) found = 1;
            end
            check("abort_reached_idx10", found, 1'b1);
            abort = 1'b1; out_ready = 1'b0;
            @(negedge clk);
            abort = 1'b0; out_ready = 1'b1;
            if (done) done_seen = 1;
            check("abort_valid", out_valid, 1'b0);
            check("abort_busy", busy, 1'b0);
            @(negedge clk);
            if (done) done_seen = 1;
            check("abort_no_done", done_seen, 1'b0);
            check("abort_count", dump_count, exp_count);
        end

        // Fresh dump after abort starts again at idx 0.
        run_dump(1'b0, -1, 0, -1);
        exp_count++;
        check("post_abort_beats", nbeats, 32);
        check("post_abort_content", content_ok, 1'b1);
        check("post_abort_count", dump_count, exp_count);

        // Start and abort in the same IDLE cycle: abort wins.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", busy, 1'b0);

        // Counter wrap on the 3-bit instance.
        while (exp_count < 10) begin
            run_dump(1'b1, -1, 0, -1);
            exp_count++;
        end
        check("wrap_full_count", dump_count, exp_count);
        check("wrap_small_count", s_dump_count, 3'(exp_count % 8));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
